// File: rtl/sin_dds_gen.sv
// ============================================================================
// Module   : sin_dds_gen
// Function : phase-accumulator DDS with a folded quarter-wave sine table.
//            Optional cosine output enabled by `define SIN_DDS_COS_OUT_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sin_dds_gen #(
    parameter int PHASE_W   = 32,
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 16,
    parameter     INIT_FILE = "sin_quarter.mem"
) (
    input  logic              clka,
    input  logic              rstn,
    input  logic              en,
    input  logic              cfg_wr,
    input  logic [PHASE_W-1:0] ftw_in,
    input  logic [PHASE_W-1:0] poff_in,
    input  logic              phase_clr,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic [ADDR_W-1:0] dout_idx
`ifdef SIN_DDS_COS_OUT_EN
    ,
    output logic [DATA_W-1:0] dout_cos,
    output logic [ADDR_W-1:0] dout_cos_idx
`endif
);

    localparam int                c_q        = 2 ** (ADDR_W - 2);
    localparam int                c_n        = 2 ** ADDR_W;
    localparam logic [ADDR_W-2:0] c_q_addr   = (ADDR_W-1)'(c_q);
    localparam logic [ADDR_W-1:0] c_cos_step = ADDR_W'(c_q);
    localparam real               c_pi       = 3.14159265358979323846;
    localparam real               c_amp      = (2.0 ** (DATA_W - 1)) - 1.0;

    // The table is regenerated from the same formula that produced INIT_FILE,
    // so the build never depends on the file being present.
    if (ADDR_W < 4 || PHASE_W <= ADDR_W || DATA_W < 2 || DATA_W > 32 || INIT_FILE == "") begin : g_bad_cfg
        $error("sin_dds_gen: unsupported parameter combination");
    end

    function automatic int lut_entry(input int j);
        real x;
        real s;
        real t;
        x = 2.0 * c_pi * real'(j) / real'(c_n);
        s = x;
        t = x;
        for (int n = 1; n <= 12; n++) begin
            t = -t * x * x / real'((2 * n) * (2 * n + 1));
            s = s + t;
        end
        return $rtoi(c_amp * s + 0.5);
    endfunction

    // Quadrants 1 and 3 run the table backwards; entry Q covers the peak.
    function automatic logic [ADDR_W-2:0] fold_addr(input logic [ADDR_W-1:0] i);
        logic [ADDR_W-2:0] k;
        k = {1'b0, i[ADDR_W-3:0]};
        return i[ADDR_W-2] ? (c_q_addr - k) : k;
    endfunction

    logic [DATA_W-2:0] w_rom [0:c_q];

    for (genvar j = 0; j <= c_q; j++) begin : g_rom
        assign w_rom[j] = (DATA_W-1)'(lut_entry(j));
    end

    // ---------------- stage 0: accumulator and phase offset ----------------
    logic [PHASE_W-1:0] r_acc;
    logic [PHASE_W-1:0] r_ftw;
    logic [PHASE_W-1:0] r_poff;
    logic [ADDR_W-1:0]  r_idx0;
    logic               r_v0;
    logic [PHASE_W-1:0] w_phase;
    logic               w_unused_phase_lsbs;

    assign w_phase             = r_acc + r_poff;
    assign w_unused_phase_lsbs = ^w_phase[PHASE_W-ADDR_W-1:0];

    always_ff @(posedge clka) begin
        if (!rstn) begin
            r_acc  <= '0;
            r_ftw  <= '0;
            r_poff <= '0;
            r_idx0 <= '0;
            r_v0   <= 1'b0;
        end else begin
            if (cfg_wr) begin
                r_ftw  <= ftw_in;
                r_poff <= poff_in;
            end
            r_v0 <= en;
            if (en) begin
                r_idx0 <= w_phase[PHASE_W-1 -: ADDR_W];
            end
            if (phase_clr) begin
                r_acc <= '0;
            end else if (en) begin
                r_acc <= r_acc + r_ftw;
            end
        end
    end

    // ---------------- stage 1: folded table read ----------------
    logic [DATA_W-2:0] r_lut;
    logic              r_neg1;
    logic [ADDR_W-1:0] r_idx1;
    logic              r_v1;

    always_ff @(posedge clka) begin
        if (!rstn) begin
            r_lut  <= '0;
            r_neg1 <= 1'b0;
            r_idx1 <= '0;
            r_v1   <= 1'b0;
        end else begin
            r_v1 <= r_v0;
            if (r_v0) begin
                r_lut  <= w_rom[fold_addr(r_idx0)];
                r_neg1 <= r_idx0[ADDR_W-1];
                r_idx1 <= r_idx0;
            end
        end
    end

    // ---------------- stage 2: sign restore ----------------
    logic [DATA_W-1:0] w_mag;
    assign w_mag = {1'b0, r_lut};

    always_ff @(posedge clka) begin
        if (!rstn) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            dout_idx   <= '0;
        end else begin
            dout_valid <= r_v1;
            if (r_v1) begin
                dout     <= r_neg1 ? (-w_mag) : w_mag;
                dout_idx <= r_idx1;
            end
        end
    end

`ifdef SIN_DDS_COS_OUT_EN
    // Cosine is the sine a quarter period ahead, read on a second port.
    logic [ADDR_W-1:0] w_cidx0;
    logic [DATA_W-2:0] r_clut;
    logic              r_cneg1;
    logic [ADDR_W-1:0] r_cidx1;
    logic [DATA_W-1:0] w_cmag;

    assign w_cidx0 = r_idx0 + c_cos_step;
    assign w_cmag  = {1'b0, r_clut};

    always_ff @(posedge clka) begin
        if (!rstn) begin
            r_clut       <= '0;
            r_cneg1      <= 1'b0;
            r_cidx1      <= '0;
            dout_cos     <= '0;
            dout_cos_idx <= '0;
        end else begin
            if (r_v0) begin
                r_clut  <= w_rom[fold_addr(w_cidx0)];
                r_cneg1 <= w_cidx0[ADDR_W-1];
                r_cidx1 <= w_cidx0;
            end
            if (r_v1) begin
                dout_cos     <= r_cneg1 ? (-w_cmag) : w_cmag;
                dout_cos_idx <= r_cidx1;
            end
        end
    end
`else
    // Sine-only build: a single table read port.
`endif

endmodule

`default_nettype wire

// File: doc/sin_dds_gen.md
Name: sin_dds_gen

Overview:
- Parametrised successor to the fixed 1024x16 sin_rom.
- Combines a phase accumulator with a quarter-wave sine LUT using symmetry folding. Outputs a signed sine stream of configurable width and resolution at a programmable frequency and phase offset.
- Feeds the DAC/modulation datapath in the FPGA user logic, replacing externally driven addressing of sin_rom.

Parameters:
- PHASE_W, 32, phase accumulator / tuning word width.
- ADDR_W, 10, full-cycle table resolution (N = 2^ADDR_W points per period); must be >= 4.
- DATA_W, 16, signed output width; peak amplitude A = 2^(DATA_W-1)-1.
- INIT_FILE, "sin_quarter.mem", $readmemh file with Q+1 entries (Q = 2^(ADDR_W-2)).

Ports:
- clka  in  1  clock, all logic rising-edge.
- rstn  in  1  synchronous active-low reset.
- en  in  1  sample strobe; one sample generated per cycle en=1.
- cfg_wr  in  1  load strobe for ftw_in/poff_in.
- ftw_in  in  PHASE_W  frequency tuning word.
- poff_in  in  PHASE_W  phase offset.
- phase_clr  in  1  synchronous accumulator clear.
- dout  out  DATA_W  signed sine sample.
- dout_valid  out  1  dout qualifier.
- dout_idx  out  ADDR_W  full-cycle index the sample came from (debug).

Behaviour:
- Reset (rstn=0 at clock edge): acc, ftw, poff, all pipeline regs = 0. dout=0, dout_valid=0, dout_idx=0. Reset mid-stream discards in-flight samples; first valid no earlier than 3 cycles after an en following reset release.
- Config: cfg_wr=1 registers ftw_in/poff_in. New values affect samples from the next cycle on. cfg_wr and en in the same cycle: that en sample uses the old values.
- Stage 0, en=1:
  - p0 = acc + poff (mod 2^PHASE_W); acc <= acc + ftw (natural wrap); v0 <= 1.
  - en=0: acc holds, v0 <= 0.
- phase_clr=1: acc <= 0, overriding the increment. If en is also 1, that sample uses the pre-clear acc. The next sample uses 0 + poff.
- Stage 1:
  - idx = p0[PHASE_W-1 -: ADDR_W] (truncation, no rounding).
  - q = idx[ADDR_W-1:ADDR_W-2]; k = idx[ADDR_W-3:0].
  - LUT address: q=0 -> k; q=1 -> Q-k; q=2 -> k; q=3 -> Q-k.
  - neg = q[1]. Registered LUT read (block-RAM inferable), v1 <= v0.
- LUT contents: entry j = round(A*sin(2*pi*j/N)), j=0..Q. Entry 0 = 0, entry Q = A.
- Stage 2: dout <= neg ? -lut : lut; dout_valid <= v1; dout_idx <= idx (pipelined).
  - Negation needs no saturation: |lut| <= A, so -A is the minimum and -2^(DATA_W-1) never occurs.
- Latency: fixed 3 clocks from en edge to dout_valid. Back-to-back en yields one sample/cycle, no bubbles.
- dout holds its last value while dout_valid=0.

Optional Feature:
- Macro: SIN_DDS_COS_OUT_EN.
- Defined:
  - Extra ports dout_cos (out, DATA_W) and dout_cos_idx (out, ADDR_W).
  - Cosine index = idx + Q (mod N), folded with the same rules via a second LUT read port.
  - Same latency and same dout_valid; dout_cos=0 on reset.
- Undefined: ports absent, single read port, no cosine logic.

Test Plan (defaults):
- Reset then basic sweep: rstn=0 for 2 cycles, release, cfg_wr with ftw=2^22, poff=0, en=1 continuous.
  - dout_valid rises exactly 3 cycles after first en.
  - Samples at idx 0,256,512,768 = 0, 32767, 0, -32767.
  - Period exactly 1024 samples; idx increments by 1 per sample.
- Symmetry check: full 1024-sample period.
  - dout[i] == dout[512-i] for i in 1..255.
  - dout[i+512] == -dout[i] for all i.
  - Output never equals -32768.
- Phase offset: ftw=0, poff=2^30.
  - Constant dout=32767 (idx 256); with cosine macro, dout_cos=0.
- Wrap and clear: ftw=2^31 gives alternating 0,0 (idx 0,512).
  - phase_clr asserted mid-stream with en=1: the following sample has idx 0.
  - Accumulator wrap at 2^32 produces no glitch.
- Gapped en and mid-operation reset: en pattern 1,0,1,1,0.
  - dout_valid mirrors the pattern delayed 3 cycles.
  - rstn=0 one cycle mid-stream clears dout_valid next edge; the restarted sequence begins at idx 0.
